// File: rtl/data_mem_pkg.sv
// Shared constants and types for the single-cycle datapath data memory.
// DATA_MEM_PRELOAD_EN (optional): preload mem[i] = i at reset instead of zero.
package data_mem_pkg;

    localparam int DM_ADDR_W = 6;
    localparam int DM_DATA_W = 32;
    localparam int DM_DEPTH  = 64;

    typedef logic [DM_ADDR_W-1:0] dm_addr_t;
    typedef logic [DM_DATA_W-1:0] dm_word_t;

endpackage : data_mem_pkg

// File: rtl/data_mem_array.sv
// Storage array for data_mem: async-reset clear/preload plus the synchronous write port.
// DATA_MEM_PRELOAD_EN: reset loads each word with its own index instead of zero.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    // Reset wins over a coincident write edge; an X on wr_en falls through as no write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef DATA_MEM_PRELOAD_EN
                mem_r[i] <= DATA_W'(i);
`else
                mem_r[i] <= {DATA_W{1'b0}};
`endif
            end
        end else if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

    // Asynchronous read so a write becomes visible right after its edge.
    always_comb begin
        rd_data = mem_r[addr];
    end

endmodule : data_mem_array

// File: rtl/data_mem.sv
// Word-addressed data memory: combinational read gated by MemRead, write on clk rising edge.
// DATA_MEM_PRELOAD_EN: selects index preload at reset (see data_mem_array).
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] rd_word_s;

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (MemWrite),
        .addr    (addr),
        .wr_data (data_in),
        .rd_data (rd_word_s)
    );

    // Read data reaches the write-back mux only when a load is in progress.
    always_comb begin
        if (MemRead) begin
            data_out = rd_word_s;
        end else begin
            data_out = {DATA_W{1'b0}};
        end
    end

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem in the default build (no preload).
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int total = 0;
    int bad   = 0;

    data_mem dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (data_out === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, data_out, exp);
        end
    endtask

    // Apply inputs at the falling edge, then settle 1 time unit.
    task automatic drive(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead  = r;
        MemWrite = w;
        addr     = a;
        data_in  = d;
        #1;
    endtask

    // Single write cycle: set up at negedge, commit at the next posedge.
    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 6'd2; data_in = 32'h0;
        #1;
        check("rst_active_read", 32'h0000_0000);
        #11;
        rst = 1'b0;

        drive(1'b1, 1'b0, 6'd2, 32'h0);
        check("reset_read_a2", 32'h0000_0000);
        drive(1'b1, 1'b0, 6'd0, 32'h0);
        check("reset_read_a0", 32'h0000_0000);

        write_word(6'd14, 32'h0000_006E);
        drive(1'b1, 1'b0, 6'd14, 32'h0);
        check("wr_rd_a14", 32'h0000_006E);
        drive(1'b0, 1'b0, 6'd14, 32'h0);
        check("gate_off_a14", 32'h0000_0000);
        drive(1'b1, 1'b0, 6'd13, 32'h0);
        check("neighbour_a13", 32'h0000_0000);
        drive(1'b1, 1'b0, 6'd15, 32'h0);
        check("neighbour_a15", 32'h0000_0000);

        write_word(6'd5, 32'h1111_2222);
        drive(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        check("rw_before_edge", 32'h1111_2222);
        @(posedge clk);
        #1;
        check("rw_after_edge", 32'hDEAD_BEEF);
        MemWrite = 1'b0;

        write_word(6'd20, 32'hA5A5_A5A5);
        drive(1'b1, 1'b0, 6'd20, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("wr_disabled_a20", 32'hA5A5_A5A5);

        drive(1'b1, 1'bx, 6'd20, 32'h0000_0000);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        #1;
        check("x_write_ignored", 32'hA5A5_A5A5);

        write_word(6'd0, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 6'd0, 32'h0);
        check("wr_rd_a0", 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 6'd1, 32'h0);
        check("neighbour_a1", 32'h0000_0000);

        write_word(6'd63, 32'h1234_5678);
        drive(1'b1, 1'b0, 6'd63, 32'h0);
        check("wr_rd_a63", 32'h1234_5678);

        // Reset mid-cycle with a write pending: clears immediately, write never lands.
        drive(1'b1, 1'b1, 6'd63, 32'hFFFF_0000);
        rst = 1'b1;
        #1;
        check("async_rst_a63", 32'h0000_0000);
        addr = 6'd5;
        #1;
        check("async_rst_a5", 32'h0000_0000);
        addr = 6'd63;
        @(posedge clk);
        #1;
        check("wr_during_rst", 32'h0000_0000);
        drive(1'b1, 1'b0, 6'd63, 32'h0);
        rst = 1'b0;
        #1;
        check("after_rst_a63", 32'h0000_0000);

        write_word(6'd7, 32'h0000_0077);
        drive(1'b1, 1'b0, 6'd7, 32'h0);
        check("first_wr_after_rst", 32'h0000_0077);
        drive(1'b1, 1'b0, 6'd14, 32'h0);
        check("cleared_a14", 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_mem
